// File: rtl/in_debounce_if.sv
// Signal bundle between the raw-input conditioner and its consumer.
// The master drives the raw input and observes the conditioned outputs.
interface in_debounce_if;
  logic       in_async;
  logic       db_level;
  logic       db_rise;
  logic       db_fall;
  logic [7:0] glitch_cnt;

  modport master (
    output in_async,
    input  db_level, db_rise, db_fall, glitch_cnt
  );

  modport slave (
    input  in_async,
    output db_level, db_rise, db_fall, glitch_cnt
  );
endinterface

// File: rtl/in_debounce.sv
// Synchronizes a raw asynchronous input, rejects pulses shorter than the hold
// time, and presents a clean level, one-cycle edge strobes and a glitch count.
module in_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  in_debounce_if.slave  db_io
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_s;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [7:0]             glitch_q, glitch_d;

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q   <= '0;
      state_q  <= STABLE_LO;
      cnt_q    <= '0;
      level_q  <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      glitch_q <= 8'd0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], db_io.in_async};
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      level_q  <= level_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      glitch_q <= glitch_d;
    end
  end

  // A WAIT state aborted by the old level counts as one rejected transition.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    level_d  = level_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    glitch_d = glitch_q;
    case (state_q)
      STABLE_LO: begin
        if (sync_s) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_HI: begin
        if (!sync_s) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          if (glitch_q != 8'hFF) glitch_d = glitch_q + 8'd1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!sync_s) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_W'(1);
        end
      end
      WAIT_LO: begin
        if (sync_s) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
          if (glitch_q != 8'hFF) glitch_d = glitch_q + 8'd1;
        end else if (cnt_q == CNT_LAST) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  assign db_io.db_level   = level_q;
  assign db_io.db_rise    = rise_q;
  assign db_io.db_fall    = fall_q;
  assign db_io.glitch_cnt = glitch_q;

endmodule

// File: tb/tb_in_debounce.sv
// Scenario bench for in_debounce at default parameters: expected edge strobes
// are queued with their due cycle when stimulus is driven and matched by a monitor.
module tb_in_debounce;

  typedef struct {
    logic isRise;
    int   cycle;
  } evT;

  // Stimulus-to-commit latency in edges with SYNC_STAGES=2, DEBOUNCE_CYCLES=4.
  localparam int LAT = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cycleCount = 0;
  int   checks = 0;
  int   passes = 0;
  int   expGlitch = 0;
  evT   expQ[$];

  in_debounce_if dbIf ();

  in_debounce #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .CNT_W(16)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .db_io(dbIf)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  // Every observed strobe must match the oldest pending expectation.
  always @(negedge clk) begin
    if (dbIf.db_rise === 1'b1 && dbIf.db_fall === 1'b1) begin
      checks++;
      $display("[TB] FAIL edge_exclusive: rise=%b fall=%b at cycle %0d, required not both 1",
               dbIf.db_rise, dbIf.db_fall, cycleCount);
    end else if (dbIf.db_rise === 1'b1 || dbIf.db_fall === 1'b1) begin
      evT ev;
      checks++;
      if (expQ.size() == 0) begin
        $display("[TB] FAIL unexpected_edge: rise=%b fall=%b at cycle %0d, required no edge",
                 dbIf.db_rise, dbIf.db_fall, cycleCount);
      end else begin
        ev = expQ.pop_front();
        if (ev.isRise !== dbIf.db_rise || ev.cycle != cycleCount || dbIf.db_level !== ev.isRise)
          $display("[TB] FAIL edge_event: rise=%b level=%b cycle=%0d, required rise=%b level=%b cycle=%0d",
                   dbIf.db_rise, dbIf.db_level, cycleCount, ev.isRise, ev.isRise, ev.cycle);
        else
          passes++;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pushEdge(input logic isRise, input int cyc);
    evT ev;
    ev.isRise = isRise;
    ev.cycle  = cyc;
    expQ.push_back(ev);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dbIf.in_async = 1'b1;
    tick(3);
    checks++;
    if ({dbIf.db_level, dbIf.db_rise, dbIf.db_fall} !== 3'b000 || dbIf.glitch_cnt !== 8'd0)
      $display("[TB] FAIL reset_outputs: level/rise/fall=%b%b%b glitch=%0d, required 000 and 0",
               dbIf.db_level, dbIf.db_rise, dbIf.db_fall, dbIf.glitch_cnt);
    else passes++;
    rst_n = 1'b1;
    pushEdge(1'b1, cycleCount + LAT);
    tick(LAT - 1);
    checks++;
    if (dbIf.db_level !== 1'b0)
      $display("[TB] FAIL reset_release_early: level=%b, required 0", dbIf.db_level);
    else passes++;
    tick(6);
    checks++;
    if (dbIf.db_level !== 1'b1 || expQ.size() != 0)
      $display("[TB] FAIL reset_release_rise: level=%b pending=%0d, required 1 and 0",
               dbIf.db_level, expQ.size());
    else passes++;
  endtask

  task automatic test_clean_rise_fall();
    dbIf.in_async = 1'b0;
    pushEdge(1'b0, cycleCount + LAT);
    tick(10);
    dbIf.in_async = 1'b1;
    pushEdge(1'b1, cycleCount + LAT);
    tick(20);
    checks++;
    if (dbIf.db_level !== 1'b1)
      $display("[TB] FAIL clean_rise_level: level=%b, required 1", dbIf.db_level);
    else passes++;
    dbIf.in_async = 1'b0;
    pushEdge(1'b0, cycleCount + LAT);
    tick(10);
    checks++;
    if (dbIf.db_level !== 1'b0 || dbIf.glitch_cnt !== 8'(expGlitch) || expQ.size() != 0)
      $display("[TB] FAIL clean_fall: level=%b glitch=%0d pending=%0d, required 0, %0d, 0",
               dbIf.db_level, dbIf.glitch_cnt, expQ.size(), expGlitch);
    else passes++;
  endtask

  task automatic test_short_pulse();
    dbIf.in_async = 1'b1;
    tick(3);
    dbIf.in_async = 1'b0;
    expGlitch++;
    tick(10);
    checks++;
    if (dbIf.db_level !== 1'b0 || dbIf.glitch_cnt !== 8'(expGlitch))
      $display("[TB] FAIL short_pulse_reject: level=%b glitch=%0d, required 0 and %0d",
               dbIf.db_level, dbIf.glitch_cnt, expGlitch);
    else passes++;
    dbIf.in_async = 1'b1;
    pushEdge(1'b1, cycleCount + LAT);
    tick(4);
    dbIf.in_async = 1'b0;
    pushEdge(1'b0, cycleCount + LAT);
    tick(12);
    checks++;
    if (dbIf.db_level !== 1'b0 || dbIf.glitch_cnt !== 8'(expGlitch) || expQ.size() != 0)
      $display("[TB] FAIL min_pulse_accept: level=%b glitch=%0d pending=%0d, required 0, %0d, 0",
               dbIf.db_level, dbIf.glitch_cnt, expQ.size(), expGlitch);
    else passes++;
  endtask

  task automatic test_bounce();
    logic pattern [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      dbIf.in_async = pattern[i];
      if (i == 4) pushEdge(1'b1, cycleCount + LAT);
      tick(1);
    end
    expGlitch += 2;
    tick(12);
    checks++;
    if (dbIf.db_level !== 1'b1 || dbIf.glitch_cnt !== 8'(expGlitch) || expQ.size() != 0)
      $display("[TB] FAIL bounce_rise: level=%b glitch=%0d pending=%0d, required 1, %0d, 0",
               dbIf.db_level, dbIf.glitch_cnt, expQ.size(), expGlitch);
    else passes++;
    dbIf.in_async = 1'b0;
    pushEdge(1'b0, cycleCount + LAT);
    tick(10);
    checks++;
    if (dbIf.db_level !== 1'b0 || expQ.size() != 0)
      $display("[TB] FAIL bounce_fall: level=%b pending=%0d, required 0 and 0",
               dbIf.db_level, expQ.size());
    else passes++;
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 300; i++) begin
      dbIf.in_async = 1'b1;
      tick(2);
      dbIf.in_async = 1'b0;
      tick(2);
    end
    expGlitch = (expGlitch + 300 > 255) ? 255 : expGlitch + 300;
    tick(6);
    checks++;
    if (dbIf.glitch_cnt !== 8'(expGlitch) || dbIf.db_level !== 1'b0)
      $display("[TB] FAIL saturation: glitch=%0d level=%b, required %0d and 0",
               dbIf.glitch_cnt, dbIf.db_level, expGlitch);
    else passes++;
    dbIf.in_async = 1'b1;
    tick(2);
    dbIf.in_async = 1'b0;
    tick(6);
    checks++;
    if (dbIf.glitch_cnt !== 8'd255)
      $display("[TB] FAIL saturation_hold: glitch=%0d, required 255", dbIf.glitch_cnt);
    else passes++;
  endtask

  task automatic test_reset_mid();
    dbIf.in_async = 1'b1;
    pushEdge(1'b1, cycleCount + LAT);
    tick(10);
    dbIf.in_async = 1'b0;
    tick(4);
    checks++;
    if (dbIf.db_level !== 1'b1)
      $display("[TB] FAIL reset_mid_pre: level=%b, required 1", dbIf.db_level);
    else passes++;
    rst_n = 1'b0;
    tick(1);
    expGlitch = 0;
    checks++;
    if ({dbIf.db_level, dbIf.db_rise, dbIf.db_fall} !== 3'b000 || dbIf.glitch_cnt !== 8'd0)
      $display("[TB] FAIL reset_mid: level/rise/fall=%b%b%b glitch=%0d, required 000 and 0",
               dbIf.db_level, dbIf.db_rise, dbIf.db_fall, dbIf.glitch_cnt);
    else passes++;
    rst_n = 1'b1;
    tick(10);
    checks++;
    if (dbIf.db_level !== 1'b0 || dbIf.glitch_cnt !== 8'd0 || expQ.size() != 0)
      $display("[TB] FAIL reset_mid_after: level=%b glitch=%0d pending=%0d, required 0, 0, 0",
               dbIf.db_level, dbIf.glitch_cnt, expQ.size());
    else passes++;
  endtask

  initial begin
    dbIf.in_async = 1'b0;
    test_reset();
    test_clean_rise_fall();
    test_short_pulse();
    test_bounce();
    test_saturation();
    test_reset_mid();
    tick(2);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/in_debounce.md
# in_debounce

Upstream conditioning stage for the registered single-bit capture stage: takes a raw asynchronous input (pin, switch, external strobe), synchronizes it into `clk`, rejects pulses shorter than a programmable hold time, and presents a clean level plus one-cycle edge strobes. `db_level` drives the capture stage's data input directly. A saturating glitch counter supports bring-up diagnostics.

## Interface
- `SYNC_STAGES`, 2: synchronizer flop count; legal range 2–4.
- `DEBOUNCE_CYCLES`, 4: consecutive synchronized samples required to accept a new level; legal range 2–65535.
- `CNT_W`, 16: debounce counter width; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `clk` input 1: single clock; all logic on the rising edge.
- `rst_n` input 1: reset, synchronous and active-low (sampled on `clk` rising edge; low = reset).
- `in_async` input 1: raw asynchronous input.
- `db_level` output 1: debounced level, registered.
- `db_rise` output 1: one-cycle pulse when `db_level` goes 0→1.
- `db_fall` output 1: one-cycle pulse when `db_level` goes 1→0.
- `glitch_cnt` output 8: count of rejected transitions, saturating at 255.

## Operation
- Synchronizer: shift chain of `SYNC_STAGES` flops; `s` = last stage output. No logic between stages.
- FSM states: STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO. Counter `cnt` (CNT_W bits).
- STABLE_LO: `s`=1 → WAIT_HI, `cnt`←1; else hold.
- WAIT_HI: `s`=0 → STABLE_LO, `cnt`←0, `glitch_cnt`++ (saturating). `s`=1 and `cnt`=DEBOUNCE_CYCLES−1 → STABLE_HI, `db_level`←1, `db_rise`←1, `cnt`←0. `s`=1 otherwise → `cnt`++.
- STABLE_HI / WAIT_LO: mirror image with polarities swapped; commit sets `db_level`←0 and `db_fall`←1.
- `db_rise`/`db_fall` are 0 on every cycle except the commit cycle; never both 1.
- `db_level` changes only on a commit; it never toggles during a WAIT state.
- `glitch_cnt` holds at 255 once reached; clears only by reset.
- Counter compare is exact equality; `cnt` never exceeds DEBOUNCE_CYCLES−1.

## Timing
- Reset (`rst_n`=0 at a rising edge): all synchronizer flops 0, state STABLE_LO, `cnt` 0, `db_level` 0, `db_rise` 0, `db_fall` 0, `glitch_cnt` 0. Reset overrides all other activity, including mid-WAIT and commit cycles; no edge pulse is emitted for a reset-induced level drop.
- First edge after `rst_n` returns to 1 is normal operation. An `in_async` already high after reset produces a normal debounced rise, with `db_rise`.
- Latency: if `in_async` is sampled high at edge E0 and stays high, `db_level`/`db_rise` assert after edge E0+SYNC_STAGES+DEBOUNCE_CYCLES−1. Defaults: 6th edge counting E0 as the 1st. The same latency applies to falls.
- Accepted pulse: `s` must equal the new value on DEBOUNCE_CYCLES consecutive FSM samples. A pulse of DEBOUNCE_CYCLES−1 synchronized cycles is always rejected and counted as one glitch.
- Bounce during a WAIT state restarts qualification from STABLE; each aborted WAIT counts once.
- Edge pulses are exactly one cycle wide and coincide with the cycle `db_level` first shows the new value.

## Test plan
- Reset: hold `rst_n`=0 3 cycles with `in_async`=1 → all outputs 0. Release; `db_level`=1 with `db_rise`=1 on the 6th edge after release (defaults).
- Clean rise/fall: `in_async` 0→1, held 20 cycles, then 1→0 → `db_rise` 1 cycle at E0+5, `db_fall` 1 cycle 6 edges after the fall sample, `glitch_cnt`=0.
- Short pulse: `in_async` high for exactly 3 cycles (DEBOUNCE_CYCLES=4) → `db_level` stays 0, no edge pulses, `glitch_cnt`=1. A 4-cycle pulse → accepted.
- Bounce: toggle `in_async` 1,0,1,0,1 at 1-cycle intervals, then hold 1 → `glitch_cnt`=2 (two aborted WAIT_HI). A single `db_rise` follows once 4 stable samples accumulate.
- Saturation: inject 300 2-cycle pulses → `glitch_cnt`=255 and holds; `db_level` stays 0.
- Reset mid-operation: assert `rst_n`=0 in WAIT_LO with `db_level`=1 → next edge `db_level`=0, `db_fall`=0, `glitch_cnt`=0.
